// File: rtl/FIFO_pkg.sv
// -----------------------------------------------------------------------------
// FIFO_pkg
// Shared definitions for the asynchronous FIFO and its write-side adapter.
//
// Contents:
//   FIFO_WIDTH     - data word width used by the FIFO and its adapters
//   ADP_CNT_WIDTH  - default width of the adapter statistics counters
//   ADP_STATE_e    - occupancy state of the write adapter skid buffer.
//                    The encoding equals the number of buffered words.
//   adp_occ()      - converts an ADP_STATE_e value into a word count
// -----------------------------------------------------------------------------
package FIFO_pkg;

   localparam int FIFO_WIDTH    = 32;
   localparam int ADP_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      A_EMPTY = 2'd0,
      A_ONE   = 2'd1,
      A_TWO   = 2'd2
   } ADP_STATE_e;

   // Number of words held in the skid buffer for a given state.
   // The illegal encoding 2'b11 reports zero so that it never enables a write.
   function automatic logic [1:0] adp_occ(input ADP_STATE_e s);
      logic [1:0] occ;
      case (s)
         A_EMPTY: occ = 2'd0;
         A_ONE:   occ = 2'd1;
         A_TWO:   occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Once the count reaches
// all-ones it holds there until cleared. A clear in the same cycle as an
// increment wins, so the result of that edge is zero.
//
// Ports:
//   clk  - clock, rising-edge active
//   rst  - asynchronous active-high reset, clears the count
//   inc  - add one on the next edge (ignored when saturated)
//   clr  - zero the count on the next edge (priority over inc)
//   q    - current count
// -----------------------------------------------------------------------------
module sat_counter
   import FIFO_pkg::*;
#(
   parameter int WIDTH = ADP_CNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;
   logic             w_at_max;

   assign w_at_max = (r_q == {WIDTH{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (inc && !w_at_max) begin
         r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/fifo_wr_adapter.sv
// -----------------------------------------------------------------------------
// fifo_wr_adapter
// Write-side adapter between a valid/ready stream producer and the write port
// of the asynchronous FIFO, running in the wclk domain. A two-entry skid
// buffer (head/tail) decouples the upstream handshake from the FIFO full
// flag. A write is only issued while full is low, so the FIFO is never
// written when full.
//
// Handshake: upstream word is taken on a rising edge when s_valid && s_ready.
// s_ready depends only on registered state (and reset), never on full or
// s_valid. Downstream, a word leaves on a rising edge when w_en is high;
// w_en = (occupancy != 0) && !full and is combinational on full.
//
// Ports:
//   wclk        - write-domain clock, rising-edge active
//   wrst        - asynchronous active-high reset; discards buffered words
//   s_valid     - upstream word available
//   s_ready     - adapter can accept a word this cycle
//   s_data      - upstream word
//   full        - FIFO full flag, synchronous to wclk
//   w_en        - FIFO write enable
//   data_in     - FIFO write data (always the head entry; holds when empty)
//   clr_stats   - synchronous clear of both statistics counters
//   wr_count    - words written into the FIFO, saturating
//   stall_count - cycles with data pending while full was high, saturating
//   dbg_state   - current occupancy state, for checkers
// -----------------------------------------------------------------------------
module fifo_wr_adapter
   import FIFO_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_pkg::FIFO_WIDTH,
   parameter int CNT_WIDTH  = ADP_CNT_WIDTH
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [FIFO_WIDTH-1:0] s_data,
   input  logic                  full,
   output logic                  w_en,
   output logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  clr_stats,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  stall_count,
   output ADP_STATE_e            dbg_state
);

   // ---------------------------------------------------------------------------
   // State and storage
   // ---------------------------------------------------------------------------
   ADP_STATE_e            r_state;
   ADP_STATE_e            w_state_nxt;
   logic [FIFO_WIDTH-1:0] r_head;
   logic [FIFO_WIDTH-1:0] r_tail;

   logic                  w_has_data;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_head_ld_in;    // head <= s_data
   logic                  w_head_ld_tail;  // head <= tail
   logic                  w_tail_ld_in;    // tail <= s_data
   logic                  w_stall;

   assign w_has_data = (adp_occ(r_state) != 2'd0);

   // wrst gates both outputs directly so they drop the instant reset rises,
   // without waiting for the state register to be observed as cleared.
   assign s_ready  = (r_state != A_TWO) && (r_state != A_EMPTY || 1'b1) && !wrst;
   assign w_en     = w_has_data && !full && !wrst;
   assign data_in  = r_head;

   assign w_accept = s_valid && s_ready;
   assign w_pop    = w_en;
   assign w_stall  = w_has_data && full;

   // ---------------------------------------------------------------------------
   // Occupancy FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_state <= A_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Occupancy FSM: next state and buffer load controls
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_head_ld_in   = 1'b0;
      w_head_ld_tail = 1'b0;
      w_tail_ld_in   = 1'b0;

      case (r_state)
         A_EMPTY: begin
            if (w_accept) begin
               w_state_nxt  = A_ONE;
               w_head_ld_in = 1'b1;
            end
         end

         A_ONE: begin
            if (w_accept && w_pop) begin
               // Head leaves and the incoming word replaces it: no bubble.
               w_state_nxt  = A_ONE;
               w_head_ld_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt  = A_TWO;
               w_tail_ld_in = 1'b1;
            end else if (w_pop) begin
               // Head is left untouched so data_in holds its last value.
               w_state_nxt  = A_EMPTY;
            end
         end

         A_TWO: begin
            // s_ready is low here, so only a pop can move the state.
            if (w_pop) begin
               w_state_nxt    = A_ONE;
               w_head_ld_tail = 1'b1;
            end
         end

         default: begin
            w_state_nxt = A_EMPTY;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Skid buffer storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_head_ld_in) begin
            r_head <= s_data;
         end else if (w_head_ld_tail) begin
            r_head <= r_tail;
         end

         if (w_tail_ld_in) begin
            r_tail <= s_data;
         end
      end
   end

   assign dbg_state = r_state;

   // ---------------------------------------------------------------------------
   // Statistics counters
   // ---------------------------------------------------------------------------
   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_wr_count (
      .clk (wclk),
      .rst (wrst),
      .inc (w_pop),
      .clr (clr_stats),
      .q   (wr_count)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_stall_count (
      .clk (wclk),
      .rst (wrst),
      .inc (w_stall),
      .clr (clr_stats),
      .q   (stall_count)
   );

endmodule
